// File: rtl/debounce_edge_if.sv
// Button conditioning bus: raw input in, debounced level, edge pulses and press count out.
interface debounce_edge_if #(
  parameter int unsigned PRESS_WIDTH = 8
);
  logic                   btn_in;
  logic                   btn_level;
  logic                   rise_pulse;
  logic                   fall_pulse;
  logic [PRESS_WIDTH-1:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, rise_pulse, fall_pulse, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, rise_pulse, fall_pulse, press_count
  );
endinterface

// File: rtl/debounce_edge.sv
// Two-flop synchronizer plus a four-state debounce FSM producing a clean level,
// single-cycle rise/fall pulses and a wrapping count of accepted presses.
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned PRESS_WIDTH     = 8
) (
  input  logic            clk,
  input  logic            reset,
  debounce_edge_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic                   r_sync0;
  logic                   r_sync1;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_cnt_last;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [PRESS_WIDTH-1:0] r_press;
  logic                   w_level_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic [PRESS_WIDTH-1:0] w_press_nxt;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // State, counter, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_press <= '0;
    end else begin
      r_sync0 <= bus.btn_in;
      r_sync1 <= r_sync0;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_press <= w_press_nxt;
    end
  end

  // Next state and stability counter; any disagreeing sample restarts the wait
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync1) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      WAIT_HIGH: begin
        if (!r_sync1) begin
          w_state_nxt = IDLE_LOW;
        end else if (w_cnt_last) begin
          w_state_nxt = IDLE_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      IDLE_HIGH: begin
        if (!r_sync1) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      WAIT_LOW: begin
        if (r_sync1) begin
          w_state_nxt = IDLE_HIGH;
        end else if (w_cnt_last) begin
          w_state_nxt = IDLE_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
      end
    endcase
  end

  // Output updates happen only on the edge that accepts a transition
  always_comb begin
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_press_nxt = r_press;
    if (r_state == WAIT_HIGH && r_sync1 && w_cnt_last) begin
      w_level_nxt = 1'b1;
      w_rise_nxt  = 1'b1;
      w_press_nxt = r_press + PRESS_WIDTH'(1);
    end
    if (r_state == WAIT_LOW && !r_sync1 && w_cnt_last) begin
      w_level_nxt = 1'b0;
      w_fall_nxt  = 1'b1;
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.rise_pulse  = r_rise;
  assign bus.fall_pulse  = r_fall;
  assign bus.press_count = r_press;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with DEBOUNCE_CYCLES=4: reset, clean press,
// release, bounce rejection, reset mid-wait and press counter wrap.
module tb_debounce_edge;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  debounce_edge_if #(.PRESS_WIDTH(8)) bus ();

  debounce_edge #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (16),
    .PRESS_WIDTH    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic lvl, input logic rise,
                          input logic fall, input logic [7:0] cnt);
    chk({tag, ".level"}, 32'(bus.btn_level), 32'(lvl));
    chk({tag, ".rise"},  32'(bus.rise_pulse), 32'(rise));
    chk({tag, ".fall"},  32'(bus.fall_pulse), 32'(fall));
    chk({tag, ".count"}, 32'(bus.press_count), 32'(cnt));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.btn_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    bus.btn_in = 1'b0;

    // Reset, including input activity while held
    tick();
    tick();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      bus.btn_in = ~bus.btn_in;
      tick();
      chk_outs("reset_toggle", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    bus.btn_in = 1'b0;
    reset      = 1'b0;
    tick();
    tick();
    chk_outs("idle_low", 1'b0, 1'b0, 1'b0, 8'd0);

    // Clean press: input high before edge 0, accepted after edge 5
    bus.btn_in = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_outs("press_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    chk_outs("press_edge5", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    chk_outs("press_edge6", 1'b1, 1'b0, 1'b0, 8'd1);
    tick();
    chk_outs("press_hold", 1'b1, 1'b0, 1'b0, 8'd1);

    // Release from IDLE_HIGH
    bus.btn_in = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_outs("release_wait", 1'b1, 1'b0, 1'b0, 8'd1);
    end
    tick();
    chk_outs("release_edge5", 1'b0, 1'b0, 1'b1, 8'd1);
    tick();
    chk_outs("release_edge6", 1'b0, 1'b0, 1'b0, 8'd1);

    // Bounce 1,0,1,1,0,1 then held: single rise 5 edges after the last 1 begins (edge 10)
    do_reset();
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int e = 0; e < 10; e++) begin
        bus.btn_in = (e < 6) ? pat[5-e] : 1'b1;
        tick();
        chk_outs("bounce_quiet", 1'b0, 1'b0, 1'b0, 8'd0);
      end
    end
    tick();
    chk_outs("bounce_edge10", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    chk_outs("bounce_edge11", 1'b1, 1'b0, 1'b0, 8'd1);

    // Reset on edge 3 inside WAIT_HIGH, input kept high
    do_reset();
    bus.btn_in = 1'b1;
    tick();
    tick();
    tick();
    chk_outs("midwait_pre", 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    tick();
    chk_outs("midwait_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    for (int e = 4; e < 9; e++) begin
      tick();
      chk_outs("midwait_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    chk_outs("midwait_edge9", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    chk_outs("midwait_edge10", 1'b1, 1'b0, 1'b0, 8'd1);

    // 256 press/release cycles: count wraps 255 -> 0 with a rise pulse
    do_reset();
    tick();
    for (int p = 0; p < 256; p++) begin
      bus.btn_in = 1'b1;
      for (int e = 0; e < 6; e++) tick();
      chk_outs("wrap_rise", 1'b1, 1'b1, 1'b0, 8'((p + 1) % 256));
      bus.btn_in = 1'b0;
      for (int e = 0; e < 6; e++) tick();
      chk_outs("wrap_fall", 1'b0, 1'b0, 1'b1, 8'((p + 1) % 256));
    end
    tick();
    chk_outs("wrap_end", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
Conditions a raw, asynchronous push-button or switch input into a clean, clock-synchronous level. Also generates single-cycle rise and fall pulses. Sits directly upstream of the D-register stages: `btn_level` or `rise_pulse` drives their `d` input. Adds a wrapping press counter for board-level observation.

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples of the new value required to accept a transition. Legal range is 2..2^CNT_WIDTH-1.
- `CNT_WIDTH`, default 16: width of the internal stability counter.
- `PRESS_WIDTH`, default 8: width of the `press_count` output.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on rising `clk`.
- `btn_in`  input  1  raw asynchronous button/switch input.
- `btn_level`  output  1  debounced level, registered.
- `rise_pulse`  output  1  one-cycle high when `btn_level` goes 0->1, registered.
- `fall_pulse`  output  1  one-cycle high when `btn_level` goes 1->0, registered.
- `press_count`  output  PRESS_WIDTH  number of accepted rising transitions, registered.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous, active-high; it dominates every other condition on the same edge.
- Reset values:
  - `sync0` = 0, `sync1` = 0.
  - state = IDLE_LOW, `cnt` = 0.
  - `btn_level` = 0, `rise_pulse` = 0, `fall_pulse` = 0, `press_count` = 0.
- Synchronizer:
  - `sync0` <= `btn_in`, then `sync1` <= `sync0`.
  - The FSM only ever looks at `sync1`; `btn_in` is never used combinationally.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - If `sync1` = 1: go to WAIT_HIGH, `cnt` <= 1.
  - Otherwise stay, `cnt` <= 0.
- WAIT_HIGH:
  - If `sync1` = 0: return to IDLE_LOW, `cnt` <= 0, no pulse (glitch rejected).
  - Else if `cnt` = DEBOUNCE_CYCLES-1: go to IDLE_HIGH, `btn_level` <= 1, `rise_pulse` <= 1, `press_count` <= `press_count`+1, `cnt` <= 0.
  - Else `cnt` <= `cnt`+1.
- IDLE_HIGH and WAIT_LOW: mirror images of the two states above.
  - Exiting WAIT_LOW sets `btn_level` <= 0 and `fall_pulse` <= 1.
  - `press_count` is unchanged on a fall.
- Pulses:
  - `rise_pulse` and `fall_pulse` are high for exactly one cycle and are 0 on every other cycle.
  - They are never high simultaneously.
- Latency:
  - `btn_in` becomes stable before edge k.
  - `btn_level` changes after edge k+1+DEBOUNCE_CYCLES, in the same cycle the pulse is asserted.
  - With the default, that is after edge k+5.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES synchronized samples produces no output change, no pulse and no count.
- Wrap-around: `press_count` wraps modulo 2^PRESS_WIDTH (255 -> 0), and that increment still asserts `rise_pulse`.
- Reset mid-operation: reset during WAIT_x aborts the pending transition; outputs and `cnt` go to their reset values on that edge.
- Input held high through reset: after reset deasserts, the block goes through the normal sequence and produces one `rise_pulse` and `press_count` = 1.
- `cnt` never exceeds DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: assert `reset` 2 cycles with `btn_in` = 0 -> all outputs 0 and state IDLE_LOW; `btn_in` toggling during reset causes no outputs to change.
- Clean press: set `btn_in` = 1 before edge 0 and hold.
  - `btn_level` = 1 and `rise_pulse` = 1 after edge 5; `rise_pulse` = 0 after edge 6.
  - `press_count` = 1.
- Bounce: `btn_in` pattern 1,0,1,1,0,1 (one cycle each) then held 1.
  - No pulse during the bounce.
  - Exactly one `rise_pulse`, 5 edges after the final stable 1 begins; `press_count` = 1.
- Release: from the IDLE_HIGH state, set `btn_in` = 0 and hold → `fall_pulse` high one cycle 5 edges later, `btn_level` = 0, `press_count` unchanged.
- Wrap: 256 clean press/release cycles → `press_count` goes 255 -> 0 with `rise_pulse` asserted on the wrapping edge.
- Reset mid-wait: `btn_in` = 1, assert `reset` on edge 3 (inside WAIT_HIGH), release it, keep `btn_in` = 1.
  - No pulse before reset.
  - Single `rise_pulse` 5 edges after reset deasserts; `press_count` = 1.
